// File: rtl/interrupt_ctrl_if.sv
// interrupt_ctrl_if: pin, strobe and control signals between the 6502 core and its interrupt controller
interface interrupt_ctrl_if;
  logic       nmi;
  logic       irq;
  logic       fetch;
  logic       brk_op;
  logic       i_flag;
  logic       vec_lo_rd;
  logic       vec_hi_rd;
  logic       int_req;
  logic       pc_inc_inh;
  logic       wr_inh;
  logic       push_b;
  logic [7:0] vector_lo;
  logic       busy;
  modport slave (
    input  nmi, irq, fetch, brk_op, i_flag, vec_lo_rd, vec_hi_rd,
    output int_req, pc_inc_inh, wr_inh, push_b, vector_lo, busy
  );
  modport master (
    output nmi, irq, fetch, brk_op, i_flag, vec_lo_rd, vec_hi_rd,
    input  int_req, pc_inc_inh, wr_inh, push_b, vector_lo, busy
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: reset/NMI/IRQ/BRK sequencing with NMI hijack for a 6502-style core
module interrupt_ctrl (
  input  logic            clk,
  input  logic            reset,
  interrupt_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEQ, VECT} state_t;
  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;
  state_t     state_q, state_d;
  src_t       src_q, src_d, src_eff;
  logic [3:0] nmi_sh_q;
  logic [1:0] irq_sh_q;
  logic       nmi_pend_q, nmi_pend_d;
  logic       reset_pend_q, reset_pend_d;
  logic       brk_q, brk_d;
  logic       nmi_fall, irq_pend, hw_pend, take, fin;
  // [1:0] are the synchronizers; [3:2] only delay the synced NMI for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_sh_q     <= '1;
      irq_sh_q     <= '1;
      nmi_pend_q   <= 1'b0;
      reset_pend_q <= 1'b1;
      state_q      <= SEQ;
      src_q        <= SRC_RST;
      brk_q        <= 1'b0;
    end else begin
      nmi_sh_q     <= {nmi_sh_q[2:0], bus.nmi};
      irq_sh_q     <= {irq_sh_q[0], bus.irq};
      nmi_pend_q   <= nmi_pend_d;
      reset_pend_q <= reset_pend_d;
      state_q      <= state_d;
      src_q        <= src_d;
      brk_q        <= brk_d;
    end
  end
  // next state, source latching with NMI hijack, and pending-event bookkeeping
  always_comb begin
    nmi_fall     = nmi_sh_q[3] & ~nmi_sh_q[2];
    irq_pend     = ~irq_sh_q[1] & ~bus.i_flag;
    hw_pend      = reset_pend_q | nmi_pend_q | irq_pend;
    take         = (state_q == IDLE) && bus.fetch && hw_pend;
    src_eff      = (state_q == SEQ && nmi_pend_q && (src_q == SRC_IRQ || src_q == SRC_BRK)) ? SRC_NMI : src_q;
    fin          = (state_q == VECT) && bus.vec_hi_rd;
    state_d      = state_q;
    src_d        = src_eff;
    brk_d        = brk_q;
    if (take) begin
      state_d = SEQ;
      brk_d   = 1'b0;
      if (reset_pend_q) src_d = SRC_RST;
      else if (nmi_pend_q) src_d = SRC_NMI;
      else src_d = SRC_IRQ;
    end else if (state_q == IDLE && bus.fetch && bus.brk_op) begin
      state_d = SEQ;
      src_d   = SRC_BRK;
      brk_d   = 1'b1;
    end else if (state_q == SEQ && bus.vec_lo_rd) begin
      state_d = VECT;
    end else if (fin) begin
      state_d = IDLE;
    end
    nmi_pend_d   = nmi_fall | (nmi_pend_q & ~(fin && src_q == SRC_NMI));
    reset_pend_d = reset_pend_q & ~(fin && src_q == SRC_RST);
  end
  // core-facing controls decoded from state and latched source
  always_comb begin
    bus.int_req    = take;
    bus.pc_inc_inh = take | (state_q == SEQ && !brk_q);
    bus.wr_inh     = (state_q != IDLE) && (src_q == SRC_RST);
    bus.push_b     = (state_q != IDLE) && brk_q;
    bus.busy       = state_q != IDLE;
    bus.vector_lo  = (state_q == IDLE) ? 8'hFE :
                     (src_eff == SRC_RST) ? 8'hFC :
                     (src_eff == SRC_NMI) ? 8'hFA : 8'hFE;
  end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: table vectors, corner-case sequences and a randomized run against a reference model
module tb_interrupt_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  interrupt_ctrl_if bus();
  interrupt_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_vec = 0;
  int n_miss = 0;
  // input order: {fetch, brk_op, i_flag, irq, vec_lo_rd, vec_hi_rd}; expected order: {int_req, pc_inc_inh, wr_inh, push_b}
  typedef struct packed {
    logic [5:0] in;
    logic [3:0] ex;
    logic [7:0] vl;
    logic       by;
  } vec_t;
  localparam logic [5:0] NOP = 6'b001100, FET = 6'b101100, BRK = 6'b111100, VLO = 6'b001110, VHI = 6'b001101;
  vec_t tbl [18];
  bit m_busy, m_vect, m_brk, m_rp, m_np;
  int m_src;
  bit nh[$];
  bit ih[$];
  bit e_ir, e_pc, e_wr, e_pb, e_by;
  logic [7:0] e_vl;
  int eff;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {7'b0, act}, {7'b0, exp});
  endtask
  task automatic chk_out(input string tag, input logic [3:0] ex, input logic [7:0] vl, input logic by);
    chkb({tag, ".int_req"}, bus.int_req, ex[3]);
    chkb({tag, ".pc_inc_inh"}, bus.pc_inc_inh, ex[2]);
    chkb({tag, ".wr_inh"}, bus.wr_inh, ex[1]);
    chkb({tag, ".push_b"}, bus.push_b, ex[0]);
    chk({tag, ".vector_lo"}, bus.vector_lo, vl);
    chkb({tag, ".busy"}, bus.busy, by);
  endtask
  task automatic step(input logic [5:0] in);
    @(negedge clk);
    {bus.fetch, bus.brk_op, bus.i_flag, bus.irq, bus.vec_lo_rd, bus.vec_hi_rd} = in;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {bus.fetch, bus.brk_op, bus.i_flag, bus.irq, bus.vec_lo_rd, bus.vec_hi_rd} = NOP;
    bus.nmi = 1'b1;
    #1;
    chk_out("reset", 4'b0110, 8'hFC, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic model_reset();
    m_busy = 1; m_vect = 0; m_brk = 0; m_rp = 1; m_np = 0; m_src = 0;
    nh = '{1, 1, 1, 1, 1};
    ih = '{1, 1};
  endtask
  task automatic model_eval();
    bit irq_p, hw;
    irq_p = !ih[$-1] && !bus.i_flag;
    hw    = m_rp || m_np || irq_p;
    eff   = (m_busy && !m_vect && m_np && m_src >= 2) ? 1 : m_src;
    e_ir  = !m_busy && bus.fetch && hw;
    e_pc  = e_ir || (m_busy && !m_vect && !m_brk);
    e_wr  = m_busy && m_src == 0;
    e_pb  = m_busy && m_brk;
    e_by  = m_busy;
    e_vl  = !m_busy ? 8'hFE : eff == 0 ? 8'hFC : eff == 1 ? 8'hFA : 8'hFE;
  endtask
  task automatic model_step();
    bit nset, fin_nmi;
    model_eval();
    fin_nmi = m_busy && m_vect && bus.vec_hi_rd && m_src == 1;
    nh.push_back(bus.nmi);
    ih.push_back(bus.irq);
    if (nh.size() > 8) void'(nh.pop_front());
    if (ih.size() > 8) void'(ih.pop_front());
    nset = !nh[$-3] && nh[$-4];
    if (!m_busy) begin
      if (e_ir) begin
        m_busy = 1; m_vect = 0; m_brk = 0;
        m_src = m_rp ? 0 : m_np ? 1 : 2;
      end else if (bus.fetch && bus.brk_op) begin
        m_busy = 1; m_vect = 0; m_brk = 1; m_src = 3;
      end
    end else if (!m_vect) begin
      m_src = eff;
      if (bus.vec_lo_rd) m_vect = 1;
    end else if (bus.vec_hi_rd) begin
      m_busy = 0;
      if (m_src == 0) m_rp = 0;
    end
    m_np = nset || (m_np && !fin_nmi);
  endtask
  initial begin
    tbl[0]  = '{6'b000100, 4'b0110, 8'hFC, 1'b1};
    tbl[1]  = '{6'b000110, 4'b0110, 8'hFC, 1'b1};
    tbl[2]  = '{6'b000100, 4'b0010, 8'hFC, 1'b1};
    tbl[3]  = '{6'b000101, 4'b0010, 8'hFC, 1'b1};
    tbl[4]  = '{6'b000100, 4'b0000, 8'hFE, 1'b0};
    tbl[5]  = '{6'b101000, 4'b0000, 8'hFE, 1'b0};
    tbl[6]  = '{6'b101000, 4'b0000, 8'hFE, 1'b0};
    tbl[7]  = '{6'b101000, 4'b0000, 8'hFE, 1'b0};
    tbl[8]  = '{6'b100000, 4'b1100, 8'hFE, 1'b0};
    tbl[9]  = '{6'b000100, 4'b0100, 8'hFE, 1'b1};
    tbl[10] = '{6'b000110, 4'b0100, 8'hFE, 1'b1};
    tbl[11] = '{6'b100100, 4'b0000, 8'hFE, 1'b1};
    tbl[12] = '{6'b000101, 4'b0000, 8'hFE, 1'b1};
    tbl[13] = '{6'b110100, 4'b0000, 8'hFE, 1'b0};
    tbl[14] = '{6'b000100, 4'b0001, 8'hFE, 1'b1};
    tbl[15] = '{6'b000110, 4'b0001, 8'hFE, 1'b1};
    tbl[16] = '{6'b000101, 4'b0001, 8'hFE, 1'b1};
    tbl[17] = '{6'b000100, 4'b0000, 8'hFE, 1'b0};
    {bus.fetch, bus.brk_op, bus.i_flag, bus.irq, bus.vec_lo_rd, bus.vec_hi_rd} = NOP;
    bus.nmi = 1'b1;
    do_reset();
    for (int r = 0; r < 18; r++) begin
      step(tbl[r].in);
      chk_out($sformatf("row%0d", r), tbl[r].ex, tbl[r].vl, tbl[r].by);
    end
    // NMI edge latency and edge-only behaviour
    step(NOP); bus.nmi = 1'b0;
    step(NOP); step(NOP);
    step(FET); chkb("nmi_k2.int_req", bus.int_req, 1'b0);
    step(FET); chkb("nmi_k3.int_req", bus.int_req, 1'b1); chkb("nmi_k3.pc_inc_inh", bus.pc_inc_inh, 1'b1);
    step(NOP); chk("nmi_seq.vector_lo", bus.vector_lo, 8'hFA); chkb("nmi_seq.push_b", bus.push_b, 1'b0);
    step(VLO); step(VHI); chk("nmi_vhi.vector_lo", bus.vector_lo, 8'hFA); chkb("nmi_vhi.busy", bus.busy, 1'b1);
    step(NOP); chkb("nmi_done.busy", bus.busy, 1'b0); chk("nmi_done.vector_lo", bus.vector_lo, 8'hFE);
    step(FET); chkb("nmi_level.int_req", bus.int_req, 1'b0);
    step(NOP); chkb("nmi_level.busy", bus.busy, 1'b0);
    // BRK hijacked by a later NMI
    bus.nmi = 1'b1;
    repeat (5) step(NOP);
    step(BRK); chkb("brk.int_req", bus.int_req, 1'b0); chkb("brk.pc_inc_inh", bus.pc_inc_inh, 1'b0);
    step(NOP); chk("brk.vector_lo", bus.vector_lo, 8'hFE); chkb("brk.push_b", bus.push_b, 1'b1);
    bus.nmi = 1'b0;
    step(NOP); step(NOP);
    step(NOP); chk("brk_pre.vector_lo", bus.vector_lo, 8'hFE);
    step(NOP); chk("hijack.vector_lo", bus.vector_lo, 8'hFA); chkb("hijack.push_b", bus.push_b, 1'b1);
    chkb("hijack.pc_inc_inh", bus.pc_inc_inh, 1'b0);
    step(VLO); step(VHI); chk("hijack_vhi.vector_lo", bus.vector_lo, 8'hFA);
    step(NOP); chkb("hijack_done.busy", bus.busy, 1'b0);
    // NMI beats IRQ, then the still-low IRQ is taken next
    bus.nmi = 1'b1;
    repeat (5) step(NOP);
    bus.nmi = 1'b0;
    repeat (4) step(6'b000000);
    step(6'b100000); chkb("both.int_req", bus.int_req, 1'b1);
    step(6'b000000); chk("both.vector_lo", bus.vector_lo, 8'hFA);
    step(6'b000010); step(6'b000001);
    step(6'b000000); chkb("both_done.busy", bus.busy, 1'b0);
    step(6'b100000); chkb("irq_next.int_req", bus.int_req, 1'b1);
    step(6'b000000); chk("irq_next.vector_lo", bus.vector_lo, 8'hFE); chkb("irq_next.pc_inc_inh", bus.pc_inc_inh, 1'b1);
    step(VLO); step(VHI); step(NOP);
    // reset in VECT of an NMI sequence
    bus.nmi = 1'b1;
    repeat (5) step(NOP);
    bus.nmi = 1'b0;
    repeat (4) step(NOP);
    step(FET); chkb("rst_nmi.int_req", bus.int_req, 1'b1);
    step(VLO);
    step(NOP); chk("rst_vect.vector_lo", bus.vector_lo, 8'hFA); chkb("rst_vect.busy", bus.busy, 1'b1);
    bus.nmi = 1'b1;
    reset = 1'b1;
    #1;
    chk_out("mid_reset", 4'b0110, 8'hFC, 1'b1);
    @(negedge clk); reset = 1'b0;
    step(VLO); chk("rst_seq.vector_lo", bus.vector_lo, 8'hFC);
    step(VHI); chkb("rst_seq.wr_inh", bus.wr_inh, 1'b1);
    step(NOP); chkb("rst_seq_done.busy", bus.busy, 1'b0);
    repeat (4) step(NOP);
    step(FET); chkb("nmi_discarded.int_req", bus.int_req, 1'b0);
    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.fetch     = $urandom_range(3) == 0;
      bus.brk_op    = $urandom_range(2) == 0;
      bus.i_flag    = $urandom_range(1) == 0;
      bus.vec_lo_rd = $urandom_range(3) == 0;
      bus.vec_hi_rd = $urandom_range(3) == 0;
      if ($urandom_range(7) == 0) bus.irq = ~bus.irq;
      if ($urandom_range(11) == 0) bus.nmi = ~bus.nmi;
      #1;
      model_eval();
      chk_out($sformatf("rand%0d", c), {e_ir, e_pc, e_wr, e_pb}, e_vl, e_by);
      @(posedge clk);
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
